// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds FSM state enum, default geometry/latency and byte-lane helpers.
package data_mem_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_LATENCY   = 2;
  localparam int LANE_W        = 8;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word store hits all four lanes; byte store hits only address[1:0].
  function automatic logic [3:0] lane_mask(
    input logic       byte_op,
    input logic [1:0] lane
  );
    lane_mask = byte_op ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage with one lane-masked write port, one async read port.
// Ports: i_clk, i_we[3:0] lane enables, i_waddr/i_wdata, i_raddr, o_rdata.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic [3:0]           i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we == 4'hF) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (i_we[l]) begin
          r_mem[i_waddr][l*LANE_W +: LANE_W] <=
            i_wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder: IDLE -> BUSY (LATENCY cycles) -> RESP.
// Ports: clk_i, rst_n_i, mem_req_* request, mem_resp_valid_o, mem_read_data_o.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mem_req_valid_i,
  output logic             mem_req_ready_o,
  input  logic [WIDTH-1:0] mem_address_i,
  input  logic             mem_write_enable_i,
  input  logic             mem_byte_op_i,
  input  logic [WIDTH-1:0] mem_write_data_i,
  output logic             mem_resp_valid_o,
  output logic [WIDTH-1:0] mem_read_data_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY out of range 1..15");
  end

  state_e               r_state;
  state_e               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [ADDR_BITS+1:0] r_addr;
  logic                 r_we;
  logic                 r_byte;
  logic [WIDTH-1:0]     r_wdata;
  logic [WIDTH-1:0]     r_rdata;
  logic                 w_accept;
  logic                 w_commit;
  logic [3:0]           w_we;
  logic [WIDTH-1:0]     w_wdata;
  logic [WIDTH-1:0]     w_rd;
  logic                 w_unused;

  // Upper address bits alias away.
  assign w_unused = ^mem_address_i[WIDTH-1:ADDR_BITS+2];

  assign w_accept = (r_state == IDLE) && mem_req_valid_i;
  // Reset on the commit edge aborts the access.
  assign w_commit = rst_n_i && (r_state == BUSY) &&
                    (r_cnt == '0);

  assign w_we    = (w_commit && r_we) ?
                   lane_mask(r_byte, r_addr[1:0]) : 4'b0000;
  // Byte is replicated to every lane; the mask picks one.
  assign w_wdata = r_byte ?
                   {(WIDTH/LANE_W){r_wdata[LANE_W-1:0]}} : r_wdata;

  data_mem_array #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (r_addr[ADDR_BITS+1:2]),
    .i_wdata (w_wdata),
    .i_raddr (r_addr[ADDR_BITS+1:2]),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (mem_req_valid_i) w_next = BUSY;
      BUSY:    if (r_cnt == '0)     w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_ready_o  = (r_state == IDLE);
    mem_resp_valid_o = (r_state == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= mem_address_i[ADDR_BITS+1:0];
        r_we    <= mem_write_enable_i;
        r_byte  <= mem_byte_op_i;
        r_wdata <= mem_write_data_i;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit && !r_we) r_rdata <= w_rd;
    end
  end

  assign mem_read_data_o = r_rdata;

endmodule
